// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (A: ALU, B: load) and the register-file write port.
// The master modport belongs to whoever drives the requests; the slave modport belongs to the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              clear;
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              busy;

  modport master (
    output clear, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
  );

  modport slave (
    input  clear, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: a round-robin arbiter for two writeback
// requesters, plus a sweep that zeroes X0..X30 after reset or on a clear pulse.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(ZERO_REG - 1);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              prio_q;  // 0: A wins a tie, 1: B wins a tie
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_register_q;
  logic [DATA_W-1:0] write_data_q;

  logic grant_a;
  logic grant_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StArb) begin
      grant_a = bus.a_valid && (!bus.b_valid || !prio_q);
      grant_b = bus.b_valid && (!bus.a_valid || prio_q);
    end
  end

  assign bus.a_ready       = grant_a && !bus.clear;
  assign bus.b_ready       = grant_b && !bus.clear;
  assign bus.busy          = (state_q == StClear);
  assign bus.RegWrite      = reg_write_q;
  assign bus.WriteRegister = write_register_q;
  assign bus.WriteData     = write_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StClear;
      cnt_q            <= '0;
      prio_q           <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= ZeroIdx;
      write_data_q     <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (bus.clear) begin
            // Restart the sweep; this edge issues no write.
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
          end else begin
            reg_write_q      <= 1'b1;
            write_register_q <= cnt_q;
            write_data_q     <= '0;
            cnt_q            <= cnt_q + 1'b1;
            if (cnt_q == LastIdx) state_q <= StArb;
          end
        end
        StArb: begin
          if (bus.clear) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
          end else if (bus.a_ready) begin
            reg_write_q      <= (bus.a_reg != ZeroIdx);
            write_register_q <= bus.a_reg;
            write_data_q     <= bus.a_data;
            prio_q           <= 1'b1;
          end else if (bus.b_ready) begin
            reg_write_q      <= (bus.b_reg != ZeroIdx);
            write_register_q <= bus.b_reg;
            write_data_q     <= bus.b_data;
            prio_q           <= 1'b0;
          end else begin
            reg_write_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file behind the write port.
module tb_regfile_wb_arbiter;

  localparam logic [63:0] Mult = 64'h0000010204080001;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  logic [63:0] rf [32] = '{default: 64'hDEAD_BEEF_0BAD_F00D};
  bit          wrote_zero_reg = 1'b0;

  regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RegWrite) rf[bus.WriteRegister] <= bus.WriteData;
    if (bus.RegWrite && bus.WriteRegister == 5'd31) wrote_zero_reg <= 1'b1;
  end

  function automatic logic [63:0] rf_read(input int idx);
    return (idx == 31) ? 64'h0 : rf[idx];
  endfunction

  // Checks each of the 31 sweep writes; starts and ends at a negedge.
  task automatic expect_sweep(input string tag);
    for (int i = 0; i < 31; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0)
        $display("FAIL %s busy/ready i=%0d: busy=%b a_ready=%b b_ready=%b, need 1 0 0",
                 tag, i, bus.busy, bus.a_ready, bus.b_ready);
      else passes++;
      @(negedge clk);
      checks++;
      if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'(i), 64'h0})
        $display("FAIL %s write i=%0d: RegWrite=%b WriteRegister=%0d WriteData=%h, need 1 %0d 0",
                 tag, i, bus.RegWrite, bus.WriteRegister, bus.WriteData, i);
      else passes++;
    end
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy_end: busy=%b, need 0", tag, bus.busy);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_reg = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.a_ready, bus.b_ready, bus.RegWrite, bus.WriteRegister, bus.WriteData}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 64'h0})
      $display("FAIL reset_state: busy=%b a_ready=%b b_ready=%b RegWrite=%b WR=%0d WD=%h, need 1 0 0 0 31 0",
               bus.busy, bus.a_ready, bus.b_ready, bus.RegWrite, bus.WriteRegister, bus.WriteData);
    else passes++;
    bus.a_valid = 1'b0;
    reset = 1'b0;
    expect_sweep("reset_sweep");
    @(negedge clk);
    checks++;
    if (bus.RegWrite !== 1'b0) $display("FAIL reset_idle: RegWrite=%b, need 0", bus.RegWrite);
    else passes++;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf_read(i) !== 64'h0) $display("FAIL reset_rf X%0d: read %h, need 0", i, rf_read(i));
      else passes++;
    end
  endtask

  task automatic test_contention();
    int ai = 1;
    int bi = 11;
    bit exp_a;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.a_reg  = 5'(ai);
      bus.a_data = 64'(ai) * Mult;
      bus.b_reg  = 5'(bi);
      bus.b_data = 64'(bi) * Mult;
      exp_a = (k % 2 == 0);
      #1;
      checks++;
      if (bus.a_ready !== exp_a || bus.b_ready !== !exp_a)
        $display("FAIL contention_grant k=%0d: a_ready=%b b_ready=%b, need %b %b",
                 k, bus.a_ready, bus.b_ready, exp_a, !exp_a);
      else passes++;
      @(negedge clk);
      checks++;
      if ({bus.RegWrite, bus.WriteRegister} !== {1'b1, 5'(exp_a ? ai : bi)})
        $display("FAIL contention_write k=%0d: RegWrite=%b WR=%0d, need 1 %0d",
                 k, bus.RegWrite, bus.WriteRegister, exp_a ? ai : bi);
      else passes++;
      if (exp_a) ai++;
      else bi++;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    for (int r = 1; r <= 14; r++) begin
      if (r > 4 && r < 11) continue;
      checks++;
      if (rf_read(r) !== 64'(r) * Mult)
        $display("FAIL contention_rf X%0d: read %h, need %h", r, rf_read(r), 64'(r) * Mult);
      else passes++;
    end
  endtask

  task automatic test_single();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 64'h00000000000000A0;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0)
      $display("FAIL single_ready: a_ready=%b b_ready=%b, need 1 0", bus.a_ready, bus.b_ready);
    else passes++;
    @(negedge clk);
    bus.a_valid = 1'b0;
    checks++;
    if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd5, 64'hA0})
      $display("FAIL single_write: RegWrite=%b WR=%0d WD=%h, need 1 5 a0",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    else passes++;
    @(negedge clk);
    checks++;
    if (rf_read(5) !== 64'hA0 || bus.RegWrite !== 1'b0)
      $display("FAIL single_rf: X5=%h RegWrite=%b, need a0 0", rf_read(5), bus.RegWrite);
    else passes++;
  endtask

  task automatic test_zero_reg();
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd31;
    bus.b_data  = 64'hFFFF;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) $display("FAIL zero_ready: b_ready=%b, need 1", bus.b_ready);
    else passes++;
    @(negedge clk);
    bus.b_valid = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd31)
      $display("FAIL zero_write: RegWrite=%b WR=%0d, need 0 31", bus.RegWrite, bus.WriteRegister);
    else passes++;
    @(negedge clk);
    checks++;
    if (wrote_zero_reg !== 1'b0 || rf_read(31) !== 64'h0)
      $display("FAIL zero_rf: wrote_zero_reg=%b X31=%h, need 0 0", wrote_zero_reg, rf_read(31));
    else passes++;
  endtask

  task automatic test_clear_mid_traffic();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd7;
    bus.a_data  = 64'h77;
    bus.clear   = 1'b1;
    #1;
    checks++;
    if (bus.a_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL clear_ready: a_ready=%b busy=%b, need 0 0", bus.a_ready, bus.busy);
    else passes++;
    @(negedge clk);
    bus.clear = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b0) $display("FAIL clear_cancel: RegWrite=%b, need 0", bus.RegWrite);
    else passes++;
    expect_sweep("clear_sweep");
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) $display("FAIL clear_resume: a_ready=%b, need 1", bus.a_ready);
    else passes++;
    @(negedge clk);
    bus.a_valid = 1'b0;
    checks++;
    if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd7, 64'h77})
      $display("FAIL clear_pending: RegWrite=%b WR=%0d WD=%h, need 1 7 77",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    else passes++;
    for (int r = 1; r <= 30; r++) begin
      if (r != 1 && r != 5 && r != 14 && r != 30) continue;
      checks++;
      if (rf_read(r) !== 64'h0) $display("FAIL clear_rf X%0d: read %h, need 0", r, rf_read(r));
      else passes++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.WriteRegister !== 5'd11 || bus.busy !== 1'b1)
      $display("FAIL midsweep_pos: WR=%0d busy=%b, need 11 1", bus.WriteRegister, bus.busy);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd31)
      $display("FAIL midsweep_reset: RegWrite=%b WR=%0d, need 0 31", bus.RegWrite, bus.WriteRegister);
    else passes++;
    expect_sweep("midsweep_restart");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.clear   = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_reg   = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_reg   = '0;
    bus.b_data  = '0;
    @(negedge clk);
    test_reset();
    test_contention();
    test_single();
    test_zero_reg();
    test_clear_mid_traffic();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
